reg_file: RTL and testbench

- 32-entry x 32-bit general-purpose register file for the MIPS datapath.
- Two asynchronous (combinational) read ports (A1/RD1, A2/RD2); one synchronous write port (A3/WD3/WE3).
- Register 0 is hardwired to zero, per MIPS $zero.
- Sits between instruction decode (register addresses) and the ALU/writeback path.

---
 rtl/reg_file.sv | 39 +++
 tb/tb_reg_file.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 MIPS register file: two combinational read ports, one synchronous write port
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic                  WE3,
  input  logic [DATA_WIDTH-1:0] WD3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  wr_en;

  // $zero is never stored to, so its slot stays at the reset value of 0.
  assign wr_en = WE3 && (A3 != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[A3] <= WD3;
    end
  end

  // No write-through: a same-cycle write becomes visible only after the edge.
  assign RD1 = (A1 == '0) ? '0 : regs_q[A1];
  assign RD2 = (A2 == '0) ? '0 : regs_q[A2];

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed and randomized check of reg_file against an array model
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, A3;
  logic        WE3;
  logic [31:0] WD3;
  logic [31:0] RD1, RD2;

  logic [31:0] model [32];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .A1    (A1),
    .A2    (A2),
    .A3    (A3),
    .WE3   (WE3),
    .WD3   (WD3),
    .RD1   (RD1),
    .RD2   (RD2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  // One rising edge; the model takes the same inputs the DUT samples.
  task automatic clock_edge();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (WE3 && A3 != 5'd0) begin
      model[A3] = WD3;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; WE3 = 1'b0; A1 = 5'd1; A2 = 5'd0; A3 = 5'd0; WD3 = 32'd0;
    for (int i = 0; i < 32; i++) model[i] = 32'hx;
    @(negedge clk);
    clock_edge();
    reset = 1'b0;
    #1;
    check("rst_rd1", RD1, 32'd0);
    check("rst_rd2", RD2, 32'd0);
    for (int a = 0; a < 32; a++) begin
      A1 = 5'(a);
      #1;
      check($sformatf("rst_sweep_%0d", a), RD1, 32'd0);
    end

    WE3 = 1'b1; A3 = 5'd2; WD3 = 32'd9; A1 = 5'd2;
    #1;
    check("rdw_before_edge", RD1, 32'd0);
    clock_edge();
    check("rdw_after_edge", RD1, 32'd9);
    WE3 = 1'b0;
    #1;
    check("wr_rd_r2", RD1, 32'd9);

    WE3 = 1'b0; A3 = 5'd6; WD3 = 32'd6;
    clock_edge();
    A2 = 5'd6;
    #1;
    check("we0_r6", RD2, 32'd0);
    check("we0_r2_kept", RD1, 32'd9);

    WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFF_FFFF;
    clock_edge();
    WE3 = 1'b0; A1 = 5'd0; A2 = 5'd0;
    #1;
    check("zero_rd1", RD1, 32'd0);
    check("zero_rd2", RD2, 32'd0);

    WE3 = 1'b1; A3 = 5'd31; WD3 = 32'hDEAD_BEEF;
    clock_edge();
    WE3 = 1'b0; A1 = 5'd31; A2 = 5'd31;
    #1;
    check("same_addr_rd1", RD1, 32'hDEAD_BEEF);
    check("same_addr_rd2", RD2, 32'hDEAD_BEEF);
    A2 = 5'd2;
    #1;
    check("dual_rd1", RD1, 32'hDEAD_BEEF);
    check("dual_rd2", RD2, 32'd9);

    reset = 1'b1; WE3 = 1'b1; A3 = 5'd5; WD3 = 32'd7;
    clock_edge();
    reset = 1'b0; WE3 = 1'b0; A1 = 5'd5; A2 = 5'd31;
    #1;
    check("rst_prio_r5", RD1, 32'd0);
    check("rst_mid_r31", RD2, 32'd0);
    A1 = 5'd2;
    #1;
    check("rst_mid_r2", RD1, 32'd0);

    WE3 = 1'b1; A3 = 5'd5; WD3 = 32'd3;
    clock_edge();
    WE3 = 1'b0; A1 = 5'd5;
    #1;
    check("post_rst_r5", RD1, 32'd3);

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      WE3   = ($urandom_range(0, 3) != 0);
      A3    = 5'($urandom);
      WD3   = $urandom;
      A1    = ($urandom_range(0, 2) == 0) ? A3 : 5'($urandom);
      A2    = ($urandom_range(0, 2) == 0) ? A3 : 5'($urandom);
      #1;
      check($sformatf("rnd%0d_pre_rd1", n), RD1, ref_read(A1));
      check($sformatf("rnd%0d_pre_rd2", n), RD2, ref_read(A2));
      clock_edge();
      check($sformatf("rnd%0d_post_rd1", n), RD1, ref_read(A1));
      check($sformatf("rnd%0d_post_rd2", n), RD2, ref_read(A2));
    end

    reset = 1'b0; WE3 = 1'b0;
    for (int a = 0; a < 32; a++) begin
      A1 = 5'(a); A2 = 5'(31 - a);
      #1;
      check($sformatf("final_rd1_%0d", a), RD1, ref_read(A1));
      check($sformatf("final_rd2_%0d", a), RD2, ref_read(A2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
